// File: rtl/param_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_pkg
// Brief    : Operation encoding and helpers for the universal shift register.
// Revision : 1.0
// ============================================================================
package shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  // Shift-class ops are the ones that advance the frame counter.
  function automatic logic is_shift(mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

  function automatic logic is_restart(mode_e m);
    return (m == MODE_LOAD) || (m == MODE_CLEAR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_frame_counter.sv
`default_nettype none
// ============================================================================
// Module   : shift_frame_counter
// Brief    : Counts shift ops modulo WIDTH; pulses done when a frame completes.
// Revision : 1.0
// ============================================================================
module shift_frame_counter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic             restart,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_last;

  assign w_last = (r_cnt == C_LAST);

  // Restart outranks step so a LOAD/CLEAR on the final count swallows the pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (restart) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (step) begin
      r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      r_done <= w_last;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign cnt  = r_cnt;
  assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/param_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : param_shift_reg
// Brief    : Parametrised universal shift register with frame counter.
// Revision : 1.0
// ============================================================================
module param_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("param_shift_reg: WIDTH must be >= 2");
    end
  endgenerate

  mode_e            w_mode;
  logic             w_step;
  logic             w_restart;
  logic [WIDTH-1:0] w_q_next;
  logic             w_sout_next;
  logic [WIDTH-1:0] r_q;
  logic             r_sout;

  assign w_mode    = mode_e'(mode);
  assign w_step    = en && is_shift(w_mode);
  assign w_restart = en && is_restart(w_mode);

  always_comb begin
    w_q_next    = r_q;
    w_sout_next = r_sout;
    if (en) begin
      case (w_mode)
        MODE_SHL: begin
          w_q_next    = {r_q[WIDTH-2:0], in};
          w_sout_next = r_q[WIDTH-1];
        end
        MODE_SHR: begin
          w_q_next    = {in, r_q[WIDTH-1:1]};
          w_sout_next = r_q[0];
        end
        MODE_ROL: begin
          w_q_next    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_sout_next = r_q[WIDTH-1];
        end
        MODE_ROR: begin
          w_q_next    = {r_q[0], r_q[WIDTH-1:1]};
          w_sout_next = r_q[0];
        end
        MODE_LOAD: begin
          w_q_next = load_data;
        end
        MODE_CLEAR: begin
          w_q_next    = RESET_VAL;
          w_sout_next = 1'b0;
        end
        default: begin
          w_q_next    = r_q;
          w_sout_next = r_sout;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q    <= RESET_VAL;
      r_sout <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_sout <= w_sout_next;
    end
  end

  shift_frame_counter #(
    .WIDTH (WIDTH)
  ) u_frame_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (w_step),
    .restart (w_restart),
    .cnt     (shift_cnt),
    .done    (frame_done)
  );

  assign q    = r_q;
  assign sout = r_sout;

endmodule
`default_nettype wire

// File: tb/tb_param_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_shift_reg
// Brief    : Directed self-checking bench for param_shift_reg (W=8 and W=16).
// Revision : 1.0
// ============================================================================
module tb_param_shift_reg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en8, in8, en16, in16;
  logic [2:0]  mode8, mode16;
  logic [7:0]  ld8, q8;
  logic [15:0] ld16, q16;
  logic        sout8, sout16, done8, done16;
  logic [2:0]  cnt8;
  logic [3:0]  cnt16;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  param_shift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .en(en8), .mode(mode8), .in(in8),
    .load_data(ld8), .q(q8), .sout(sout8), .shift_cnt(cnt8), .frame_done(done8)
  );

  param_shift_reg #(.WIDTH(16), .RESET_VAL(16'h8001)) dut16 (
    .clk(clk), .reset_n(reset_n), .en(en16), .mode(mode16), .in(in16),
    .load_data(ld16), .q(q16), .sout(sout16), .shift_cnt(cnt16), .frame_done(done16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [2:0] m, input logic b);
    en8 = 1'b1; mode8 = m; in8 = b;
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] a5;
    reset_n = 1'b0;
    en8 = 0; mode8 = 3'b000; in8 = 0; ld8 = '0;
    en16 = 0; mode16 = 3'b000; in16 = 0; ld16 = '0;
    #12;
    chk("rst_q8", q8, 8'h00);
    chk("rst_q16", q16, 16'h8001);
    chk("rst_cnt8", cnt8, 0);
    chk("rst_done8", done8, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // 1. async reset mid-frame
    for (int i = 0; i < 5; i++) op8(3'b001, 1'b1);
    chk("pre_rst_q", q8, 8'h1F);
    chk("pre_rst_cnt", cnt8, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("async_q", q8, 8'h00);
    chk("async_sout", sout8, 0);
    chk("async_cnt", cnt8, 0);
    chk("async_done", done8, 0);
    chk("async_q16", q16, 16'h8001);
    @(negedge clk);
    reset_n = 1'b1;
    en8 = 1'b0;
    tick();
    chk("post_rst_hold_q", q8, 8'h00);
    chk("post_rst_hold_cnt", cnt8, 0);

    // 2. SHL pattern -> A1
    pat = 8'b1010_0001;
    for (int i = 0; i < 8; i++) begin
      op8(3'b001, pat[7-i]);
      chk("shl_cnt", cnt8, (i + 1) % 8);
      chk("shl_done", done8, (i == 7) ? 1 : 0);
    end
    chk("shl_q", q8, 8'hA1);
    en8 = 1'b0;
    tick();
    chk("shl_done_clear", done8, 0);

    // 3. LOAD A5 then ROR x8
    en8 = 1'b1; mode8 = 3'b101; ld8 = 8'hA5;
    tick();
    chk("load_q", q8, 8'hA5);
    chk("load_cnt", cnt8, 0);
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      op8(3'b100, 1'b0);
      chk("ror_sout", sout8, a5[i]);
      chk("ror_done", done8, (i == 7) ? 1 : 0);
    end
    chk("ror_q", q8, 8'hA5);

    // 4. en=0 mid-frame
    for (int i = 0; i < 3; i++) op8(3'b001, 1'b0);
    chk("mid_q", q8, 8'h28);
    chk("mid_sout", sout8, 1);
    chk("mid_cnt", cnt8, 3);
    en8 = 1'b0; mode8 = 3'b001; in8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en0_q", q8, 8'h28);
      chk("en0_sout", sout8, 1);
      chk("en0_cnt", cnt8, 3);
      chk("en0_done", done8, 0);
    end
    for (int i = 0; i < 5; i++) begin
      op8(3'b001, 1'b0);
      chk("resume_done", done8, (i == 4) ? 1 : 0);
    end
    chk("resume_cnt", cnt8, 0);
    chk("resume_q", q8, 8'h00);

    // 5. LOAD aborts frame; LOAD on last count wins; back-to-back frames
    for (int i = 0; i < 5; i++) op8(3'b001, 1'b1);
    en8 = 1'b1; mode8 = 3'b101; ld8 = 8'h3C;
    tick();
    chk("abort_q", q8, 8'h3C);
    chk("abort_cnt", cnt8, 0);
    chk("abort_done", done8, 0);
    for (int i = 0; i < 7; i++) op8(3'b001, 1'b0);
    chk("pre_last_cnt", cnt8, 7);
    en8 = 1'b1; mode8 = 3'b101; ld8 = 8'h55;
    tick();
    chk("last_load_done", done8, 0);
    chk("last_load_cnt", cnt8, 0);
    chk("last_load_q", q8, 8'h55);
    for (int i = 0; i < 16; i++) begin
      op8(3'b001, 1'b0);
      chk("b2b_done", done8, (i == 7 || i == 15) ? 1 : 0);
    end
    // ROL direction change mid-frame keeps the count
    en8 = 1'b1; mode8 = 3'b101; ld8 = 8'h81;
    tick();
    op8(3'b001, 1'b0);
    op8(3'b011, 1'b0);
    chk("rol_q", q8, 8'h04);
    chk("rol_cnt", cnt8, 2);
    // CLEAR in W=8
    en8 = 1'b1; mode8 = 3'b101; ld8 = 8'hFF;
    tick();
    op8(3'b001, 1'b0);
    chk("pre_clr_sout", sout8, 1);
    op8(3'b110, 1'b0);
    chk("clr8_q", q8, 8'h00);
    chk("clr8_sout", sout8, 0);
    chk("clr8_cnt", cnt8, 0);
    en8 = 1'b0;

    // 6. WIDTH=16, RESET_VAL=8001
    chk("w16_idle_q", q16, 16'h8001);
    en16 = 1'b1; mode16 = 3'b010; in16 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("w16_cnt", cnt16, (i + 1) % 16);
      chk("w16_done", done16, (i == 15) ? 1 : 0);
    end
    chk("w16_q", q16, 16'hFFFF);
    chk("w16_sout", sout16, 1);
    mode16 = 3'b111; in16 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rsvd_q", q16, 16'hFFFF);
      chk("rsvd_sout", sout16, 1);
      chk("rsvd_cnt", cnt16, 0);
      chk("rsvd_done", done16, 0);
    end
    mode16 = 3'b110;
    tick();
    chk("clr16_q", q16, 16'h8001);
    chk("clr16_sout", sout16, 0);
    en16 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
